// File: rtl/divider.sv
// divider: iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU
// and their W forms. One quotient bit per cycle (64 or 32 cycles), with
// divide-by-zero and signed overflow resolved directly at accept.
module divider (
   input  logic        clk,
   input  logic        rst,
   input  logic        div_ready,
   input  logic [2:0]  div_op,
   input  logic [63:0] div_op1,
   input  logic [63:0] div_op2,
   output logic [63:0] div_result,
   output logic        div_finish,
   output logic        div_busy
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t      r_state;
   logic [5:0]  r_cnt;
   logic [63:0] r_dividend;   // shifts left; quotient bits enter at bit 0
   logic [63:0] r_rem;
   logic [63:0] r_divisor;
   logic        r_qsign;
   logic        r_rsign;
   logic        r_rem_op;
   logic        r_word;
   logic [63:0] r_result;
   logic        r_finish;

   // Sign fixup, quotient/remainder select, and word sign extension.
   // Word results sign-extend bit 31 for unsigned W ops as well.
   function automatic logic [63:0] fixup(input logic [63:0] q, input logic [63:0] r,
                                         input logic qs, input logic rs,
                                         input logic rem, input logic word);
      logic [63:0] v;
      v = rem ? (rs ? -r : r) : (qs ? -q : q);
      return word ? {{32{v[31]}}, v[31:0]} : v;
   endfunction

   // ---- operand preparation (IDLE / accept) ----
   logic        w_word, w_uns;
   logic [63:0] w_a, w_b, w_amag, w_bmag, w_spec_res;
   logic        w_s1, w_s2, w_dz, w_ovf;

   assign w_word = div_op[2];
   assign w_uns  = div_op[0];
   // Word ops keep [31:0]; signed extends bit 31, unsigned zero-extends.
   assign w_a    = w_word ? {{32{div_op1[31] & ~w_uns}}, div_op1[31:0]} : div_op1;
   assign w_b    = w_word ? {{32{div_op2[31] & ~w_uns}}, div_op2[31:0]} : div_op2;
   assign w_s1   = ~w_uns & w_a[63];
   assign w_s2   = ~w_uns & w_b[63];
   assign w_amag = w_s1 ? -w_a : w_a;
   assign w_bmag = w_s2 ? -w_b : w_b;
   assign w_dz   = (w_b == 64'd0);
   // After extension the most-negative word value reads as 0xFFFF_FFFF_8000_0000.
   assign w_ovf  = ~w_uns & (w_b == '1) &
                   (w_a == (w_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
   // Special results come straight from the extended operands, no sign fixup.
   assign w_spec_res = fixup(w_dz ? '1 : w_a, w_dz ? w_a : 64'd0,
                             1'b0, 1'b0, div_op[1], w_word);

   // ---- one restoring iteration ----
   logic [64:0] w_pr;
   logic        w_ge;
   logic [63:0] w_rem_nxt, w_quo_nxt, w_calc_res;

   // Partial remainder is 65 bits so the compare cannot overflow; the
   // difference itself always fits in 64 bits when it is taken.
   assign w_pr       = {r_rem, r_dividend[63]};
   assign w_ge       = (w_pr >= {1'b0, r_divisor});
   assign w_rem_nxt  = w_ge ? (w_pr[63:0] - r_divisor) : w_pr[63:0];
   assign w_quo_nxt  = {r_dividend[62:0], w_ge};
   assign w_calc_res = fixup(w_quo_nxt, w_rem_nxt, r_qsign, r_rsign, r_rem_op, r_word);

   // Control FSM and datapath; result/finish are registered on entry to DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= 6'd0;
         r_dividend <= 64'd0;
         r_rem      <= 64'd0;
         r_divisor  <= 64'd0;
         r_qsign    <= 1'b0;
         r_rsign    <= 1'b0;
         r_rem_op   <= 1'b0;
         r_word     <= 1'b0;
         r_result   <= 64'd0;
         r_finish   <= 1'b0;
      end else begin
         r_finish <= 1'b0;
         r_result <= 64'd0;
         case (r_state)
            S_IDLE: begin
               if (div_ready) begin
                  r_rem_op   <= div_op[1];
                  r_word     <= w_word;
                  r_qsign    <= w_s1 ^ w_s2;
                  r_rsign    <= w_s1;
                  r_rem      <= 64'd0;
                  r_divisor  <= w_bmag;
                  // Word dividend is left-justified so 32 shifts consume it.
                  r_dividend <= w_word ? {w_amag[31:0], 32'd0} : w_amag;
                  r_cnt      <= w_word ? 6'd31 : 6'd63;
                  if (w_dz || w_ovf) begin
                     r_state  <= S_DONE;
                     r_finish <= 1'b1;
                     r_result <= w_spec_res;
                  end else begin
                     r_state  <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               if (!div_ready) begin
                  r_state <= S_IDLE;
               end else begin
                  r_rem      <= w_rem_nxt;
                  r_dividend <= w_quo_nxt;
                  r_cnt      <= r_cnt - 6'd1;
                  if (r_cnt == 6'd0) begin
                     r_state  <= S_DONE;
                     r_finish <= 1'b1;
                     r_result <= w_calc_res;
                  end
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign div_result = r_result;
   assign div_finish = r_finish;
   assign div_busy   = (r_state != S_IDLE);

endmodule
